// File: rtl/tetris_board.sv
// Playfield store, line-clear engine and BCD score for the VGA display stage.
// Optional BOARD_FLASH_EN inserts a row blank-out hold before each row shift.
module tetris_board #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 20
`ifdef BOARD_FLASH_EN
    ,
    parameter int unsigned FLASH_CYCLES = 25000000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rd_x,
    input  logic [4:0]  rd_y,
    output logic [3:0]  rd_kind,
    input  logic [3:0]  q_x,
    input  logic [4:0]  q_y,
    output logic        q_occ,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [2:0]  wr_kind,
    input  logic        clear_req,
    input  logic        new_game,
    output logic        busy,
    output logic        done,
    output logic [2:0]  lines,
    output logic [15:0] score
);

    localparam int unsigned YW = 5;
    localparam int unsigned KW = 3;
`ifdef BOARD_FLASH_EN
    localparam int unsigned FW = $clog2(FLASH_CYCLES + 1);
`endif

    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, ADD, DONE, FLASH} state_t;

    logic [KW-1:0] cells [ROWS][COLS];
    state_t        state, state_nxt;
    logic [YW-1:0] r, r_nxt, s, s_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [3:0]    pts, pts_nxt;
    logic [15:0]   score_q, score_nxt;
    logic [2:0]    lines_q, lines_nxt;
    logic          row_full_c;
`ifdef BOARD_FLASH_EN
    logic [FW-1:0] flash_cnt, flash_nxt;
`endif

    assign score = score_q;
    assign lines = lines_q;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] o;
        logic        carry;
        o     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (o[d*4 +: 4] == 4'd9) begin
                    o[d*4 +: 4] = 4'd0;
                end else begin
                    o[d*4 +: 4] = o[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return o;
    endfunction

    function automatic logic [3:0] pts_for(input logic [2:0] n);
        case (n)
            3'd0:    return 4'd0;
            3'd1:    return 4'd1;
            3'd2:    return 4'd3;
            3'd3:    return 4'd5;
            default: return 4'd8;
        endcase
    endfunction

    // Full-row detect on the row currently under the scan pointer
    always_comb begin
        row_full_c = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (cells[r][c] == '0) row_full_c = 1'b0;
        end
    end

    // Display lookup; out-of-range reads as empty
    always_comb begin
        rd_kind = '0;
        if (32'(rd_x) < COLS && 32'(rd_y) < ROWS) rd_kind = {1'b0, cells[rd_y][rd_x]};
`ifdef BOARD_FLASH_EN
        if (state == FLASH && rd_y == r) rd_kind = '0;
`endif
    end

    // Collision lookup; walls and floor read as occupied
    always_comb begin
        q_occ = 1'b1;
        if (32'(q_x) < COLS && 32'(q_y) < ROWS) q_occ = (cells[q_y][q_x] != '0);
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        s_nxt     = s;
        cnt_nxt   = cnt;
        pts_nxt   = pts;
        score_nxt = score_q;
        lines_nxt = lines_q;
`ifdef BOARD_FLASH_EN
        flash_nxt = '0;
`endif
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = SCAN;
                    r_nxt     = YW'(ROWS - 1);
                    cnt_nxt   = '0;
                end
            end
            SCAN: begin
                if (row_full_c) begin
                    s_nxt   = r;
                    cnt_nxt = (cnt == 3'd7) ? cnt : cnt + 3'd1;
`ifdef BOARD_FLASH_EN
                    state_nxt = FLASH;
`else
                    state_nxt = SHIFT;
`endif
                end else if (r == '0) begin
                    pts_nxt   = pts_for(cnt);
                    state_nxt = ADD;
                end else begin
                    r_nxt = r - YW'(1);
                end
            end
`ifdef BOARD_FLASH_EN
            FLASH: begin
                if (32'(flash_cnt) + 1 >= FLASH_CYCLES) state_nxt = SHIFT;
                else flash_nxt = flash_cnt + FW'(1);
            end
`endif
            SHIFT: begin
                if (s == '0) state_nxt = SCAN;
                else s_nxt = s - YW'(1);
            end
            ADD: begin
                if (pts == '0) begin
                    state_nxt = DONE;
                    lines_nxt = cnt;
                end else begin
                    score_nxt = bcd_inc(score_q);
                    pts_nxt   = pts - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Wipe overrides any pass in flight
        if (new_game) begin
            state_nxt = IDLE;
            score_nxt = '0;
            lines_nxt = '0;
            cnt_nxt   = '0;
            pts_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            r        <= '0;
            s        <= '0;
            cnt      <= '0;
            pts      <= '0;
            score_q  <= '0;
            lines_q  <= '0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            done     <= 1'b0;
`ifdef BOARD_FLASH_EN
            flash_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            r        <= r_nxt;
            s        <= s_nxt;
            cnt      <= cnt_nxt;
            pts      <= pts_nxt;
            score_q  <= score_nxt;
            lines_q  <= lines_nxt;
            busy     <= (state_nxt != IDLE);
            wr_ready <= (state_nxt == IDLE);
            done     <= (state_nxt == DONE);
`ifdef BOARD_FLASH_EN
            flash_cnt <= flash_nxt;
`endif
        end
    end

    // Cell array: wipe, idle writes, and one-row-per-cycle downward shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) cells[y][x] <= '0;
        end else if (new_game) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) cells[y][x] <= '0;
        end else if (state == IDLE) begin
            if (wr_valid && 32'(wr_x) < COLS && 32'(wr_y) < ROWS) cells[wr_y][wr_x] <= wr_kind;
        end else if (state == SHIFT) begin
            if (s != '0) cells[s] <= cells[s - YW'(1)];
            else for (int x = 0; x < COLS; x++) cells[0][x] <= '0;
        end
    end

endmodule

// File: tb/tb_tetris_board.sv
// Self-checking bench for tetris_board: a board/score model feeds a scoreboard
// of expected {lines, score} that is checked on every done pulse.
module tb_tetris_board;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_x, q_x, wr_x;
    logic [4:0]  rd_y, q_y, wr_y;
    logic [3:0]  rd_kind;
    logic        q_occ, wr_valid, wr_ready, clear_req, new_game, busy, done;
    logic [2:0]  wr_kind, lines;
    logic [15:0] score;

    typedef struct packed {
        logic [2:0]  lines;
        logic [15:0] score;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          exp_score = 0;
    logic [2:0]  board [20][10];
    exp_t        sb [$];
    exp_t        mon_e;

    tetris_board dut (
        .clk(clk), .reset(reset),
        .rd_x(rd_x), .rd_y(rd_y), .rd_kind(rd_kind),
        .q_x(q_x), .q_y(q_y), .q_occ(q_occ),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_kind(wr_kind),
        .clear_req(clear_req), .new_game(new_game),
        .busy(busy), .done(done), .lines(lines), .score(score)
    );

    always #500 clk = ~clk;

    initial begin
        #60000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int pts_of(input int n);
        case (n)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 lines=%0d score=%h with no pass outstanding", lines, score);
            end else begin
                mon_e = sb.pop_front();
                if (lines !== mon_e.lines || score !== mon_e.score) begin
                    errors++;
                    $display("FAIL pass_result: lines=%0d score=%h, expected lines=%0d score=%h",
                             lines, score, mon_e.lines, mon_e.score);
                end
            end
        end
    end

    task automatic model_write(input int x, input int y, input int k);
        if (x < 10 && y < 20) board[y][x] = 3'(k);
    endtask

    task automatic model_clear(output int n);
        logic [2:0] nb [20][10];
        int  w;
        bit  full;
        w = 19;
        n = 0;
        for (int y = 0; y < 20; y++) for (int x = 0; x < 10; x++) nb[y][x] = 3'd0;
        for (int y = 19; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < 10; x++) if (board[y][x] == 3'd0) full = 1'b0;
            if (full) n++;
            else begin
                for (int x = 0; x < 10; x++) nb[w][x] = board[y][x];
                w--;
            end
        end
        board = nb;
    endtask

    task automatic push_expect(input int n);
        exp_t e;
        exp_score = exp_score + pts_of(n);
        if (exp_score > 9999) exp_score = 9999;
        e.lines = 3'(n);
        e.score = to_bcd(exp_score);
        sb.push_back(e);
    endtask

    task automatic write_cell(input int x, input int y, input int k);
        wr_valid = 1'b1;
        wr_x = 4'(x);
        wr_y = 5'(y);
        wr_kind = 3'(k);
        model_write(x, y, k);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Starts a pass (optionally with a write in the same cycle) and waits for done
    task automatic run_pass(input bit wr_en, input int x, input int y, input int k,
                            output int cycles, output bit busy_ok);
        wr_valid = wr_en;
        wr_x = 4'(x);
        wr_y = 5'(y);
        wr_kind = 3'(k);
        clear_req = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        clear_req = 1'b0;
        cycles = 1;
        busy_ok = 1'b1;
        while (!done && cycles < 400) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (!done) cycles = -1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rd_x = 4'd3; rd_y = 5'd7; #1;
        checks++; if (rd_kind !== 4'd0) begin errors++; $display("FAIL reset_rd_kind: got %0d want 0", rd_kind); end
        q_x = 4'd10; q_y = 5'd0; #1;
        checks++; if (q_occ !== 1'b1) begin errors++; $display("FAIL q_occ_wall: got %b want 1", q_occ); end
        q_x = 4'd0; q_y = 5'd20; #1;
        checks++; if (q_occ !== 1'b1) begin errors++; $display("FAIL q_occ_floor: got %b want 1", q_occ); end
        q_x = 4'd0; q_y = 5'd0; #1;
        checks++; if (q_occ !== 1'b0) begin errors++; $display("FAIL q_occ_empty: got %b want 0", q_occ); end
        checks++; if (score !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h want 0000", score); end
        checks++; if (lines !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ctrl: lines=%0d done=%b busy=%b wr_ready=%b want 0 0 0 1", lines, done, busy, wr_ready);
        end
    endtask

    task automatic test_empty_pass();
        int cyc, n;
        bit bok;
        write_cell(2, 19, 5);
        write_cell(10, 19, 7);
        model_clear(n);
        push_expect(n);
        run_pass(1'b0, 0, 0, 0, cyc, bok);
        checks++; if (cyc !== 22) begin errors++; $display("FAIL empty_latency: done at cycle %0d want 22", cyc); end
        checks++; if (!bok) begin errors++; $display("FAIL empty_busy: busy dropped before done, want high"); end
        rd_x = 4'd2; rd_y = 5'd19; #1;
        checks++; if (rd_kind !== 4'd5) begin errors++; $display("FAIL kept_cell: got %0d want 5", rd_kind); end
        rd_x = 4'd10; #1;
        checks++; if (rd_kind !== 4'd0) begin errors++; $display("FAIL rd_out_of_range: got %0d want 0", rd_kind); end
    endtask

    task automatic test_single_line();
        int cyc, n;
        bit bok;
        for (int x = 0; x < 9; x++) write_cell(x, 19, 1);
        write_cell(4, 18, 3);
        model_write(9, 19, 1);
        model_clear(n);
        push_expect(n);
        run_pass(1'b1, 9, 19, 1, cyc, bok);
        checks++; if (cyc !== 44) begin errors++; $display("FAIL single_latency: done at cycle %0d want 44", cyc); end
        for (int y = 0; y < 20; y++) for (int x = 0; x < 10; x++) begin
            rd_x = 4'(x); rd_y = 5'(y); #1;
            checks++;
            if (rd_kind !== {1'b0, board[y][x]}) begin
                errors++; $display("FAIL single_board(%0d,%0d): got %0d want %0d", x, y, rd_kind, board[y][x]);
            end
        end
    endtask

    task automatic test_tetris(input bit preload);
        int cyc, n;
        bit bok;
        if (preload) begin
            force dut.score_q = 16'h9995;
            @(negedge clk);
            release dut.score_q;
            exp_score = 9995;
        end else begin
            write_cell(0, 15, 6);
        end
        for (int y = 16; y < 20; y++) for (int x = 0; x < 10; x++) write_cell(x, y, 2);
        model_clear(n);
        push_expect(n);
        run_pass(1'b0, 0, 0, 0, cyc, bok);
        checks++; if (cyc !== 22 + 4 * 21 + 8) begin errors++; $display("FAIL tetris_latency: done at cycle %0d want 114", cyc); end
        checks++; if (score !== to_bcd(exp_score)) begin errors++; $display("FAIL tetris_score: got %h want %h", score, to_bcd(exp_score)); end
        for (int y = 0; y < 20; y++) for (int x = 0; x < 10; x++) begin
            rd_x = 4'(x); rd_y = 5'(y); #1;
            checks++;
            if (rd_kind !== {1'b0, board[y][x]}) begin
                errors++; $display("FAIL tetris_board(%0d,%0d): got %0d want %0d", x, y, rd_kind, board[y][x]);
            end
        end
        q_x = 4'd0; q_y = 5'd19; #1;
        checks++; if (q_occ !== (board[19][0] != 3'd0)) begin errors++; $display("FAIL tetris_q_occ: got %b want %b", q_occ, board[19][0] != 3'd0); end
    endtask

    task automatic test_new_game();
        int ds0;
        for (int x = 0; x < 10; x++) write_cell(x, 19, 4);
        write_cell(3, 10, 7);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (4) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        for (int y = 0; y < 20; y++) for (int x = 0; x < 10; x++) board[y][x] = 3'd0;
        exp_score = 0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL new_game_ctrl: busy=%b done=%b wr_ready=%b want 0 0 1", busy, done, wr_ready);
        end
        checks++; if (score !== 16'h0000 || lines !== 3'd0) begin
            errors++; $display("FAIL new_game_score: score=%h lines=%0d want 0000 0", score, lines);
        end
        for (int y = 0; y < 20; y++) for (int x = 0; x < 10; x++) begin
            rd_x = 4'(x); rd_y = 5'(y); #1;
            checks++;
            if (rd_kind !== 4'd0) begin errors++; $display("FAIL new_game_board(%0d,%0d): got %0d want 0", x, y, rd_kind); end
        end
        ds0 = done_seen;
        repeat (40) @(negedge clk);
        checks++; if (done_seen !== ds0) begin errors++; $display("FAIL new_game_done: %0d done pulses want 0", done_seen - ds0); end
    endtask

    task automatic test_back_to_back();
        int cyc, n, ds0;
        bit ready_seen;
        write_cell(5, 19, 2);
        model_clear(n);
        push_expect(n);
        ds0 = done_seen;
        ready_seen = 1'b0;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (cyc == 5) begin
                ready_seen = wr_ready;
                wr_valid = 1'b1; wr_x = 4'd7; wr_y = 5'd0; wr_kind = 3'd4;
            end
            if (cyc == 6) wr_valid = 1'b0;
            if (cyc == 8) clear_req = 1'b1;
            if (cyc == 9) clear_req = 1'b0;
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 22) begin errors++; $display("FAIL b2b_latency: done at cycle %0d want 22", cyc); end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL b2b_wr_ready: got %b want 0 while busy", ready_seen); end
        repeat (40) @(negedge clk);
        checks++; if (done_seen - ds0 !== 1) begin errors++; $display("FAIL b2b_done_count: %0d pulses want 1", done_seen - ds0); end
        rd_x = 4'd7; rd_y = 5'd0; #1;
        checks++; if (rd_kind !== 4'd0) begin errors++; $display("FAIL b2b_busy_write: got %0d want 0", rd_kind); end
        rd_x = 4'd5; rd_y = 5'd19; #1;
        checks++; if (rd_kind !== 4'd2) begin errors++; $display("FAIL b2b_kept: got %0d want 2", rd_kind); end
    endtask

    initial begin
        reset = 1'b1;
        rd_x = '0; rd_y = '0; q_x = '0; q_y = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_kind = '0;
        clear_req = 1'b0; new_game = 1'b0;
        for (int y = 0; y < 20; y++) for (int x = 0; x < 10; x++) board[y][x] = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_empty_pass();
        test_single_line();
        test_tetris(1'b0);
        test_tetris(1'b1);
        test_new_game();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected passes never completed", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
